// File: rtl/pc_fetch_predictor.sv
// Fetch-stage PC register with a direct-mapped 2-bit BHT and untagged target buffer.
// Redirects on a resolved mispredict from EX and keeps jump/branch/mispredict statistics.
module pc_fetch_predictor #(
  parameter int ADDR_W   = 10,
  parameter int IDX_W    = 6,
  parameter int INC      = 1,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_jumped,
  input  logic              ex_is_branch,
  input  logic              ex_branched,
  input  logic [ADDR_W-1:0] ex_pc_new,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_taken,
  output logic [ADDR_W-1:0] if_pred_target,
  output logic              flush,
  output logic [31:0]       jump_cnt,
  output logic [31:0]       branch_cnt,
  output logic [31:0]       mispred_cnt
);

  localparam int                L_ENTRIES  = 1 << IDX_W;
  localparam logic [ADDR_W-1:0] L_INC      = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0]    r_pc;
  logic [1:0]           r_bht       [L_ENTRIES];
  logic [L_ENTRIES-1:0] r_btb_valid;
  logic [ADDR_W-1:0]    r_btb_tgt   [L_ENTRIES];
  logic [31:0]          r_jump_cnt;
  logic [31:0]          r_branch_cnt;
  logic [31:0]          r_mispred_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_idx_e;
  logic              w_pred_taken;
  logic [ADDR_W-1:0] w_pred_target;
  logic [ADDR_W-1:0] w_correct_next;
  logic              w_resolves;
  logic              w_mispredict;
  logic              w_br_update;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_unused;

  // The carried prediction bit is informational only; the target compare alone decides a redirect.
  assign w_unused = ex_pred_taken;

  assign w_idx   = r_pc[IDX_W-1:0];
  assign w_idx_e = ex_pc[IDX_W-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_pred_taken  = r_bht[w_idx][1] & r_btb_valid[w_idx];
    w_pred_target = r_pc + L_INC;
    if (w_pred_taken) begin
      w_pred_target = r_btb_tgt[w_idx];
    end
  end

  always_comb begin
    w_correct_next = ex_pc + L_INC;
    if (ex_jumped || ex_branched) begin
      w_correct_next = ex_pc_new;
    end
    w_resolves   = ex_valid & (ex_jumped | ex_is_branch);
    w_mispredict = w_resolves & (w_correct_next != ex_pred_target);
    w_br_update  = ex_valid & ex_is_branch & ~ex_jumped;

    w_next_pc = w_pred_target;
    if (w_mispredict) begin
      w_next_pc = w_correct_next;
    end else if (stall) begin
      w_next_pc = r_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= L_RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // NOTE: only counters and valid bits are reset; the target array stays unreset because valid gates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L_ENTRIES; i++) begin
        r_bht[i] <= 2'b01;
      end
      r_btb_valid <= '0;
    end else if (w_br_update) begin
      if (ex_branched) begin
        if (r_bht[w_idx_e] != 2'b11) begin
          r_bht[w_idx_e] <= r_bht[w_idx_e] + 2'd1;
        end
        r_btb_valid[w_idx_e] <= 1'b1;
      end else if (r_bht[w_idx_e] != 2'b00) begin
        r_bht[w_idx_e] <= r_bht[w_idx_e] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_br_update && ex_branched) begin
      r_btb_tgt[w_idx_e] <= ex_pc_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jump_cnt    <= '0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (ex_valid && ex_jumped) begin
        r_jump_cnt <= r_jump_cnt + 32'd1;
      end
      if (w_br_update) begin
        r_branch_cnt <= r_branch_cnt + 32'd1;
      end
      if (w_mispredict) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  assign if_pc          = r_pc;
  assign if_pred_taken  = w_pred_taken;
  assign if_pred_target = w_pred_target;
  // Held low while reset is asserted even if EX inputs still claim a mispredict.
  assign flush          = w_mispredict & rst_n;
  assign jump_cnt       = r_jump_cnt;
  assign branch_cnt     = r_branch_cnt;
  assign mispred_cnt    = r_mispred_cnt;

endmodule

// File: tb/tb_pc_fetch_predictor.sv
// Bench for pc_fetch_predictor: directed EX resolutions, a table-level reference model
// compared every negedge, and hand-computed expectations at key points.
module tb_pc_fetch_predictor;

  localparam int ADDR_W = 10;
  localparam int IDX_W  = 6;
  localparam int N_IDX  = 1 << IDX_W;
  localparam int N_PC   = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_jumped;
  logic              ex_is_branch;
  logic              ex_branched;
  logic [ADDR_W-1:0] ex_pc_new;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_pred_target;
  logic [ADDR_W-1:0] if_pc;
  logic              if_pred_taken;
  logic [ADDR_W-1:0] if_pred_target;
  logic              flush;
  logic [31:0]       jump_cnt;
  logic [31:0]       branch_cnt;
  logic [31:0]       mispred_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_predictor #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .INC(1), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_jumped(ex_jumped),
    .ex_is_branch(ex_is_branch), .ex_branched(ex_branched), .ex_pc_new(ex_pc_new),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .flush(flush), .jump_cnt(jump_cnt), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: saturating integer counters, a valid flag and target per index.
  int          m_pc;
  int          m_cnt [N_IDX];
  bit          m_val [N_IDX];
  int          m_tgt [N_IDX];
  int unsigned m_jc, m_bc, m_mc;

  function automatic int m_seq(input int p);
    return (p + 1) % N_PC;
  endfunction

  function automatic bit m_pred_taken();
    return (m_cnt[m_pc % N_IDX] >= 2) && m_val[m_pc % N_IDX];
  endfunction

  function automatic int m_pred_target();
    return m_pred_taken() ? m_tgt[m_pc % N_IDX] : m_seq(m_pc);
  endfunction

  function automatic int m_correct();
    if (ex_jumped || ex_branched) return int'(ex_pc_new);
    return m_seq(int'(ex_pc));
  endfunction

  function automatic bit m_mispredict();
    return rst_n && ex_valid && (ex_jumped || ex_is_branch) && (m_correct() != int'(ex_pred_target));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 0;
      for (int i = 0; i < N_IDX; i++) begin
        m_cnt[i] <= 1;
        m_val[i] <= 1'b0;
        m_tgt[i] <= 0;
      end
      m_jc <= 0;
      m_bc <= 0;
      m_mc <= 0;
    end else begin
      if (m_mispredict()) m_pc <= m_correct();
      else if (!stall)    m_pc <= m_pred_target();
      if (ex_valid && ex_is_branch && !ex_jumped) begin
        if (ex_branched) begin
          m_cnt[int'(ex_pc) % N_IDX] <= (m_cnt[int'(ex_pc) % N_IDX] == 3) ? 3 : m_cnt[int'(ex_pc) % N_IDX] + 1;
          m_val[int'(ex_pc) % N_IDX] <= 1'b1;
          m_tgt[int'(ex_pc) % N_IDX] <= int'(ex_pc_new);
        end else begin
          m_cnt[int'(ex_pc) % N_IDX] <= (m_cnt[int'(ex_pc) % N_IDX] == 0) ? 0 : m_cnt[int'(ex_pc) % N_IDX] - 1;
        end
        m_bc <= m_bc + 1;
      end
      if (ex_valid && ex_jumped) m_jc <= m_jc + 1;
      if (m_mispredict()) m_mc <= m_mc + 1;
    end
  end

  always @(negedge clk) begin
    check("m_if_pc",          32'(if_pc),          32'(m_pc));
    check("m_if_pred_taken",  32'(if_pred_taken),  32'(m_pred_taken()));
    check("m_if_pred_target", 32'(if_pred_target), 32'(m_pred_target()));
    check("m_flush",          32'(flush),          32'(m_mispredict()));
    check("m_jump_cnt",       jump_cnt,            m_jc);
    check("m_branch_cnt",     branch_cnt,          m_bc);
    check("m_mispred_cnt",    mispred_cnt,         m_mc);
  end

  task automatic drive(input logic v, input int pc, input logic j, input logic ib, input logic br,
                       input int nw, input logic pt, input int ptg);
    ex_valid       = v;
    ex_pc          = ADDR_W'(pc);
    ex_jumped      = j;
    ex_is_branch   = ib;
    ex_branched    = br;
    ex_pc_new      = ADDR_W'(nw);
    ex_pred_taken  = pt;
    ex_pred_target = ADDR_W'(ptg);
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic jump_to(input int tgt);
    drive(1'b1, 30, 1'b1, 1'b0, 1'b0, tgt, 1'b0, 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    stall = 1'b0;
    idle();
    #1 rst_n = 1'b0;
    #11 rst_n = 1'b1;
    #1;
    check("rst_pc",          32'(if_pc), 0);
    check("rst_pred_taken",  32'(if_pred_taken), 0);
    check("rst_pred_target", 32'(if_pred_target), 1);
    check("rst_flush",       32'(flush), 0);
    check("rst_jump_cnt",    jump_cnt, 0);
    check("rst_branch_cnt",  branch_cnt, 0);
    check("rst_mispred_cnt", mispred_cnt, 0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("seq_pc", 32'(if_pc), 32'(i));
    end

    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5, 1'b0, 1'b1, 1'b1, 20, 1'b0, 6);
      #1 check("train_flush", 32'(flush), 1);
      cycle();
      check("train_redirect", 32'(if_pc), 20);
    end
    idle();
    check("train_mispred_cnt", mispred_cnt, 3);
    jump_to(5);
    cycle(); idle(); #1;
    check("trained_pc", 32'(if_pc), 5);
    check("trained_pred_taken", 32'(if_pred_taken), 1);
    check("trained_pred_target", 32'(if_pred_target), 20);
    cycle();
    check("follow_pred_pc", 32'(if_pc), 20);

    drive(1'b1, 5, 1'b0, 1'b1, 1'b1, 20, 1'b1, 20);
    #1 check("correct_flush", 32'(flush), 0);
    cycle(); idle();
    check("correct_branch_cnt", branch_cnt, 4);
    check("correct_mispred_cnt", mispred_cnt, 4);

    stall = 1'b1;
    drive(1'b1, 0, 1'b1, 1'b0, 1'b0, 100, 1'b0, 8);
    #1 check("stall_jump_flush", 32'(flush), 1);
    cycle(); idle();
    check("stall_jump_pc", 32'(if_pc), 100);
    check("stall_jump_cnt", jump_cnt, 2);
    cycle();
    check("stall_hold_pc", 32'(if_pc), 100);
    stall = 1'b0;

    drive(1'b1, 5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 6);
    #1 check("nt_correct_flush", 32'(flush), 0);
    cycle();
    check("nt_seq_pc", 32'(if_pc), 101);
    jump_to(5);
    cycle(); idle(); #1;
    check("weak_taken_pred", 32'(if_pred_taken), 1);
    drive(1'b1, 5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 6);
    #1 check("rbw_pred_taken", 32'(if_pred_taken), 1);
    cycle();
    check("rbw_old_target_pc", 32'(if_pc), 20);
    jump_to(5);
    cycle(); idle(); #1;
    check("untrained_pred_taken", 32'(if_pred_taken), 0);
    check("untrained_pred_target", 32'(if_pred_target), 6);

    jump_to(1023);
    cycle(); idle(); #1;
    check("wrap_pc", 32'(if_pc), 1023);
    check("wrap_pred_target", 32'(if_pred_target), 0);
    cycle();
    check("wrap_next_pc", 32'(if_pc), 0);

    drive(1'b1, 70, 1'b0, 1'b1, 1'b1, 300, 1'b0, 71);
    cycle();
    check("alias_train_pc", 32'(if_pc), 300);
    jump_to(6);
    cycle(); idle(); #1;
    check("alias_pred_taken", 32'(if_pred_taken), 1);
    check("alias_pred_target", 32'(if_pred_target), 300);
    drive(1'b1, 6, 1'b0, 1'b1, 1'b0, 0, 1'b1, 300);
    #1 check("alias_flush", 32'(flush), 1);
    cycle(); idle();
    check("alias_redirect_pc", 32'(if_pc), 7);
    check("alias_mispred_cnt", mispred_cnt, 11);
    check("alias_branch_cnt", branch_cnt, 8);
    check("alias_jump_cnt", jump_cnt, 6);

    drive(1'b0, 6, 1'b1, 1'b1, 1'b1, 500, 1'b0, 0);
    #1 check("invalid_flush", 32'(flush), 0);
    cycle(); idle();
    check("invalid_pc", 32'(if_pc), 8);
    check("invalid_jump_cnt", jump_cnt, 6);

    drive(1'b1, 10, 1'b1, 1'b1, 1'b1, 40, 1'b0, 11);
    #1 check("both_flush", 32'(flush), 1);
    cycle(); idle();
    check("both_pc", 32'(if_pc), 40);
    check("both_jump_cnt", jump_cnt, 7);
    check("both_branch_cnt", branch_cnt, 8);
    jump_to(10);
    cycle(); idle(); #1;
    check("both_no_table_pred", 32'(if_pred_taken), 0);

    jump_to(200);
    #1 check("arst_pre_flush", 32'(flush), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_pc", 32'(if_pc), 0);
    check("arst_flush", 32'(flush), 0);
    check("arst_jump_cnt", jump_cnt, 0);
    check("arst_branch_cnt", branch_cnt, 0);
    check("arst_mispred_cnt", mispred_cnt, 0);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("arst_release_pc", 32'(if_pc), 0);
    cycle();
    check("arst_seq_pc", 32'(if_pc), 1);
    jump_to(5);
    cycle(); idle(); #1;
    check("arst_btb_cleared", 32'(if_pred_taken), 0);
    check("arst_btb_target", 32'(if_pred_target), 6);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
